// File: rtl/test_sigchk.sv
// AXI4-Stream sink that checks the four-packet generator sequence beat by beat
// and reports packet/error counts, sticky error status and completion.
module test_sigchk #(
    parameter int TDATA_WIDTH  = 32,
    parameter int TSTRB_WIDTH  = TDATA_WIDTH/8,
    parameter int TUSER_WIDTH  = 16,
    parameter int PACKET_LEN   = 10,
    parameter int NUM_PACKETS  = 4,
    parameter int READY_PERIOD = 0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     tvalid,
    output logic                     tready,
    input  logic [8*TDATA_WIDTH-1:0] tdata,
    input  logic [8*TSTRB_WIDTH-1:0] tstrb,
    input  logic [8*TUSER_WIDTH-1:0] tuser,
    input  logic                     tlast,
    output logic [15:0]              pkt_count,
    output logic [15:0]              err_count,
    output logic                     error,
    output logic [2:0]               last_err_code,
    output logic                     done
);

    localparam int DW = 8*TDATA_WIDTH;
    localparam int SW = 8*TSTRB_WIDTH;
    localparam int UW = 8*TUSER_WIDTH;
    localparam int IW = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
    localparam int TW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [1:0]      r_pat;
    logic [IW-1:0]   r_i;
    logic            r_pkt_err;
    logic [15:0]     r_pkt_cnt;
    logic [15:0]     r_err_cnt;
    logic            r_error;
    logic [2:0]      r_code;
    logic            r_done;

    logic            w_thr_drop;
    logic            w_acc;
    logic            w_chk;
    logic            w_end;
    logic            w_last_pos;
    logic [31:0]     w_exp_val;
    logic [DW-1:0]   w_exp_data;
    logic [SW-1:0]   w_exp_strb;
    logic [UW-1:0]   w_exp_user;
    logic            w_e_data;
    logic            w_e_strb;
    logic            w_e_user;
    logic            w_e_early;
    logic            w_e_miss;
    logic [2:0]      w_code;
    logic            w_beat_err;
    logic            w_pkt_bad;
    logic [15:0]     w_pkt_next;
    logic            w_done_next;

    // Free-running throttle; tready drops on the last count of each period
    generate
        if (READY_PERIOD > 0) begin : g_thr
            logic [TW-1:0] r_thr;
            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    r_thr <= '0;
                end else if (r_thr == TW'(READY_PERIOD-1)) begin
                    r_thr <= '0;
                end else begin
                    r_thr <= r_thr + TW'(1);
                end
            end
            assign w_thr_drop = (r_thr == TW'(READY_PERIOD-1));
        end else begin : g_nothr
            assign w_thr_drop = 1'b0;
        end
    endgenerate

    assign tready = (r_state != S_DONE) && !w_thr_drop;
    assign w_acc  = tvalid && tready;
    assign w_chk  = w_acc && ((r_state == S_IDLE) || (r_state == S_RECV));
    assign w_end  = w_acc && tlast && (r_state != S_DONE);

    always_comb begin
        w_last_pos = (r_i == IW'(PACKET_LEN-1));
        w_exp_val  = 32'd50 + 32'd100 * 32'(r_pat) + 32'(r_i);
        w_exp_data = DW'(w_exp_val);
        w_exp_strb = w_last_pos ? SW'(32'h0000ffff) : {SW{1'b1}};
        w_exp_user = UW'({(r_pat[0] ? 8'hEA : 8'hAF), 24'd1});
    end

    assign w_e_data  = (tdata != w_exp_data);
    assign w_e_strb  = (tstrb != w_exp_strb);
    assign w_e_user  = (tuser != w_exp_user);
    assign w_e_early = tlast && !w_last_pos;
    assign w_e_miss  = !tlast && w_last_pos;

    // Lower code wins when several checks fail on the same beat
    always_comb begin
        w_code = 3'd0;
        if (w_e_data) begin
            w_code = 3'd1;
        end else if (w_e_strb) begin
            w_code = 3'd2;
        end else if (w_e_user) begin
            w_code = 3'd3;
        end else if (w_e_early) begin
            w_code = 3'd4;
        end else if (w_e_miss) begin
            w_code = 3'd5;
        end
    end

    assign w_beat_err  = (w_code != 3'd0);
    assign w_pkt_bad   = r_pkt_err || (w_chk && w_beat_err);
    assign w_pkt_next  = (r_pkt_cnt == 16'hFFFF) ? r_pkt_cnt
                                                 : r_pkt_cnt + 16'd1;
    assign w_done_next = (w_pkt_next == 16'(NUM_PACKETS));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_pat     <= 2'd0;
            r_i       <= '0;
            r_pkt_err <= 1'b0;
            r_pkt_cnt <= 16'd0;
            r_err_cnt <= 16'd0;
            r_error   <= 1'b0;
            r_code    <= 3'd0;
            r_done    <= 1'b0;
        end else begin
            if (w_chk && w_beat_err) begin
                r_error <= 1'b1;
                r_code  <= w_code;
            end
            if (w_end) begin
                r_pkt_cnt <= w_pkt_next;
                if (w_pkt_bad && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
                r_pat     <= r_pat + 2'd1;
                r_i       <= '0;
                r_pkt_err <= 1'b0;
                if (w_done_next) begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                end else begin
                    r_state <= S_IDLE;
                end
            end else if (w_chk) begin
                r_pkt_err <= w_pkt_bad;
                if (w_e_miss) begin
                    r_state <= S_DRAIN;
                end else begin
                    r_i     <= r_i + IW'(1);
                    r_state <= S_RECV;
                end
            end
        end
    end

    assign pkt_count     = r_pkt_cnt;
    assign err_count     = r_err_cnt;
    assign error         = r_error;
    assign last_err_code = r_code;
    assign done          = r_done;

endmodule

// File: tb/tb_test_sigchk.sv
// Bench for test_sigchk: random-gap driver, packet-level reference model
// and a scoreboard monitor comparing status after every accepted beat.
module tb_test_sigchk;

    localparam int DB = 32;
    localparam int SB = DB/8;
    localparam int UB = 16;
    localparam int PL = 10;
    localparam int NP = 4;
    localparam int RP = 3;
    localparam int DW = 8*DB;
    localparam int SW = 8*SB;
    localparam int UW = 8*UB;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          tvalid = 1'b0;
    logic          tready;
    logic [DW-1:0] tdata = '0;
    logic [SW-1:0] tstrb = '0;
    logic [UW-1:0] tuser = '0;
    logic          tlast = 1'b0;
    logic [15:0]   pkt_count;
    logic [15:0]   err_count;
    logic          error;
    logic [2:0]    last_err_code;
    logic          done;

    always #5 clk = ~clk;

    test_sigchk #(
        .TDATA_WIDTH(DB),
        .TSTRB_WIDTH(SB),
        .TUSER_WIDTH(UB),
        .PACKET_LEN(PL),
        .NUM_PACKETS(NP),
        .READY_PERIOD(RP)
    ) u_dut (
        .clk(clk),
        .resetn(resetn),
        .tvalid(tvalid),
        .tready(tready),
        .tdata(tdata),
        .tstrb(tstrb),
        .tuser(tuser),
        .tlast(tlast),
        .pkt_count(pkt_count),
        .err_count(err_count),
        .error(error),
        .last_err_code(last_err_code),
        .done(done)
    );

    typedef struct packed {
        logic [15:0] pk;
        logic [15:0] er;
        logic        e;
        logic [2:0]  c;
        logic        d;
    } st_t;

    st_t exp_q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  k_cyc = 0;

    int  m_pkts, m_errs, m_pos, m_code;
    bit  m_error, m_bad, m_done;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) k_cyc <= 0;
        else k_cyc <= k_cyc + 1;
    end

    function automatic logic [DW-1:0] pat_data(input int p, input int i);
        return DW'(50 + 100*p + i);
    endfunction

    function automatic logic [SW-1:0] pat_strb(input int i);
        return (i == PL-1) ? SW'(32'h0000ffff) : {SW{1'b1}};
    endfunction

    function automatic logic [UW-1:0] pat_user(input int p);
        return UW'({((p % 2) != 0 ? 8'hEA : 8'hAF), 24'd1});
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pkts = 0; m_errs = 0; m_pos = 0; m_code = 0;
        m_error = 0; m_bad = 0; m_done = 0;
        exp_q.delete();
    endtask

    // A packet is every beat up to the next tlast; only its first PL beats
    // are compared against the pattern.
    task automatic model_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                              input logic [UW-1:0] u, input logic l);
        int  code;
        int  p;
        st_t st;
        code = 0;
        p = m_pkts % 4;
        if (m_pos < PL) begin
            if (d != pat_data(p, m_pos)) code = 1;
            else if (s != pat_strb(m_pos)) code = 2;
            else if (u != pat_user(p)) code = 3;
            else if (l && m_pos < PL-1) code = 4;
            else if (!l && m_pos == PL-1) code = 5;
        end
        if (code != 0) begin
            m_error = 1; m_code = code; m_bad = 1;
        end
        m_pos++;
        if (l) begin
            if (m_pkts < 65535) m_pkts++;
            if (m_bad && m_errs < 65535) m_errs++;
            m_bad = 0;
            m_pos = 0;
            if (m_pkts == NP) m_done = 1;
        end
        st.pk = 16'(m_pkts);
        st.er = 16'(m_errs);
        st.e  = m_error;
        st.c  = 3'(m_code);
        st.d  = m_done;
        exp_q.push_back(st);
    endtask

    always @(negedge clk) begin
        st_t e;
        if (resetn) begin
            check("tready", {31'd0, tready},
                  (m_done || (k_cyc % RP) == RP-1) ? 32'd0 : 32'd1);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pkt_count", {16'd0, pkt_count}, {16'd0, e.pk});
                check("err_count", {16'd0, err_count}, {16'd0, e.er});
                check("error", {31'd0, error}, {31'd0, e.e});
                check("last_err_code", {29'd0, last_err_code}, {29'd0, e.c});
                check("done", {31'd0, done}, {31'd0, e.d});
            end
        end
    end

    // Inputs only change at posedge+1, so each edge is seen by the loop below
    task automatic send_beat(input logic [DW-1:0] d, input logic [SW-1:0] s,
                             input logic [UW-1:0] u, input logic l);
        int   gap;
        bit   ok;
        logic rdy;
        gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        if (gap > 0) begin
            tvalid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        tdata = d; tstrb = s; tuser = u; tlast = l; tvalid = 1'b1;
        ok = 0;
        for (int c = 0; c < 30 && !ok; c++) begin
            @(negedge clk);
            rdy = tready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1;
        end
        n_chk++;
        if (!ok) begin
            n_fail++;
            tvalid = 1'b0;
            $display("FAIL beat_timeout: got no accept expected accept");
        end else begin
            model_beat(d, s, u, l);
        end
    endtask

    task automatic send_pkt(input int p, input int len,
                            input int bad, input int kind);
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        for (int j = 0; j < len; j++) begin
            d = pat_data(p, j);
            s = pat_strb(j);
            u = pat_user(p);
            if (j == bad) begin
                if (kind == 1) d = d + 1'b1;
                else if (kind == 2) s[0] = ~s[0];
                else u[UW-1] = ~u[UW-1];
            end
            send_beat(d, s, u, j == len-1);
        end
    endtask

    task automatic go_idle();
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetn = 1'b0;
        tvalid = 1'b0;
        tlast = 1'b0;
        model_reset();
        #1;
        check("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        check("rst_err_count", {16'd0, err_count}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_code", {29'd0, last_err_code}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_tready", {31'd0, tready}, 32'd1);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic final_chk(input logic [15:0] pk, input logic [15:0] er,
                             input logic e, input logic [2:0] c);
        repeat (4) @(posedge clk);
        #1;
        check("end_pkt_count", {16'd0, pkt_count}, {16'd0, pk});
        check("end_err_count", {16'd0, err_count}, {16'd0, er});
        check("end_error", {31'd0, error}, {31'd0, e});
        check("end_code", {29'd0, last_err_code}, {29'd0, c});
        check("end_done", {31'd0, done}, 32'd1);
        check("end_tready", {31'd0, tready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        int len;
        int bad;
        model_reset();
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(p, PL, -1, 0);
        go_idle();
        final_chk(16'd4, 16'd0, 1'b0, 3'd0);

        do_reset();
        send_pkt(0, PL, -1, 0);
        send_pkt(1, PL, 5, 1);
        send_pkt(2, PL, -1, 0);
        send_pkt(3, PL, -1, 0);
        go_idle();
        final_chk(16'd4, 16'd1, 1'b1, 3'd1);

        do_reset();
        send_pkt(0, 7, -1, 0);
        for (int p = 1; p < 4; p++) send_pkt(p, PL, -1, 0);
        go_idle();
        final_chk(16'd4, 16'd1, 1'b1, 3'd4);

        do_reset();
        send_pkt(0, PL, -1, 0);
        send_pkt(1, PL, -1, 0);
        send_pkt(2, PL+1, -1, 0);
        send_pkt(3, PL, -1, 0);
        go_idle();
        final_chk(16'd4, 16'd1, 1'b1, 3'd5);

        do_reset();
        send_pkt(0, PL, -1, 0);
        for (int j = 0; j < 5; j++)
            send_beat(pat_data(1, j), pat_strb(j), pat_user(1), 1'b0);
        do_reset();
        for (int p = 0; p < 4; p++) send_pkt(p, PL, -1, 0);
        go_idle();
        final_chk(16'd4, 16'd0, 1'b0, 3'd0);

        repeat (4) begin
            do_reset();
            guard = 0;
            while (!m_done && guard < 20) begin
                len = ($urandom_range(0, 3) == 0) ?
                      int'($urandom_range(1, PL+2)) : PL;
                bad = ($urandom_range(0, 2) == 0) ?
                      int'($urandom_range(0, len-1)) : -1;
                send_pkt(m_pkts % 4, len, bad, int'($urandom_range(1, 3)));
                guard++;
            end
            go_idle();
            repeat (4) @(posedge clk);
        end

        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
